// File: rtl/gps_grid_mapper.sv
// GPS frame parser "$<lon>,<lat>*" with region check and sequential grid-index divider.
// Optional event counters (good_cnt, err_cnt) are enabled with GPS_GRID_STAT_EN.
module gps_grid_mapper #(
    parameter int NDIG    = 5,
    parameter int COORD_W = 17,
    parameter int GRID_W  = 9,
    parameter int LON_MIN = 10000,
    parameter int LON_MAX = 60000,
    parameter int LAT_MIN = 20000,
    parameter int LAT_MAX = 70000,
    parameter int CELL    = 100
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              jw_we,
    input  logic [6:0]        jw_data,
    output logic [GRID_W-1:0] m,
    output logic [GRID_W-1:0] n,
    output logic              in_region,
    output logic              out_valid,
    output logic              frame_err,
    output logic              busy
`ifdef GPS_GRID_STAT_EN
    ,
    output logic [15:0]       good_cnt,
    output logic [15:0]       err_cnt
`endif
);

    localparam int CNT_W  = $clog2(NDIG + 1);
    localparam int STEP_W = $clog2(COORD_W + 1);
    localparam int REM_W  = $clog2(CELL + 1) + 1;

    typedef enum logic [2:0] {
        S_IDLE, S_LON, S_SEP, S_LAT, S_END, S_CHECK, S_DIV, S_OUT
    } state_t;

    state_t              state_q;
    logic [COORD_W-1:0]  acc_lon_q, acc_lat_q;
    logic [COORD_W-1:0]  acc_lon_d, acc_lat_d;
    logic [CNT_W-1:0]    cnt_q;
    logic [COORD_W-1:0]  dvd_lon_q, dvd_lat_q;
    logic [REM_W-1:0]    rem_lon_q, rem_lat_q;
    logic [STEP_W-1:0]   step_q;
    logic                region_hit_q;
    logic [GRID_W-1:0]   m_q, n_q;
    logic                in_region_q, out_valid_q, frame_err_q;

    logic                is_digit_s, is_dollar_s, is_comma_s, is_star_s, region_s;
    logic [6:0]          digit_s;

    // One restoring-division step: shift the next dividend bit into the remainder, quotient bit in at LSB.
    function automatic logic [REM_W+COORD_W-1:0] div_step(input logic [REM_W-1:0] r,
                                                          input logic [COORD_W-1:0] q);
        logic [REM_W-1:0] t;
        t = {r[REM_W-2:0], q[COORD_W-1]};
        if (t >= REM_W'(CELL)) begin
            div_step = {t - REM_W'(CELL), q[COORD_W-2:0], 1'b1};
        end else begin
            div_step = {t, q[COORD_W-2:0], 1'b0};
        end
    endfunction

    function automatic logic [GRID_W-1:0] sat_idx(input logic [COORD_W-1:0] q);
        if ((q >> GRID_W) != '0) begin
            sat_idx = {GRID_W{1'b1}};
        end else begin
            sat_idx = q[GRID_W-1:0];
        end
    endfunction

    // Character classification, decimal accumulation and region test
    always_comb begin
        is_digit_s  = (jw_data >= 7'h30) && (jw_data <= 7'h39);
        is_dollar_s = (jw_data == 7'h24);
        is_comma_s  = (jw_data == 7'h2C);
        is_star_s   = (jw_data == 7'h2A);
        digit_s     = jw_data - 7'h30;
        acc_lon_d   = acc_lon_q * COORD_W'(10) + COORD_W'(digit_s);
        acc_lat_d   = acc_lat_q * COORD_W'(10) + COORD_W'(digit_s);
        region_s    = (acc_lon_q >= COORD_W'(LON_MIN)) && (acc_lon_q <= COORD_W'(LON_MAX)) &&
                      (acc_lat_q >= COORD_W'(LAT_MIN)) && (acc_lat_q <= COORD_W'(LAT_MAX));
    end

    // Frame FSM, dividers and registered outputs
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            acc_lon_q    <= '0;
            acc_lat_q    <= '0;
            cnt_q        <= '0;
            dvd_lon_q    <= '0;
            dvd_lat_q    <= '0;
            rem_lon_q    <= '0;
            rem_lat_q    <= '0;
            step_q       <= '0;
            region_hit_q <= 1'b0;
            m_q          <= '0;
            n_q          <= '0;
            in_region_q  <= 1'b0;
            out_valid_q  <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            out_valid_q <= 1'b0;
            frame_err_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (jw_we && is_dollar_s) begin
                        acc_lon_q <= '0;
                        acc_lat_q <= '0;
                        cnt_q     <= '0;
                        state_q   <= S_LON;
                    end
                end
                S_LON, S_LAT: begin
                    if (jw_we) begin
                        if (is_dollar_s) begin
                            acc_lon_q <= '0;
                            acc_lat_q <= '0;
                            cnt_q     <= '0;
                            state_q   <= S_LON;
                        end else if (is_digit_s) begin
                            if (state_q == S_LON) begin
                                acc_lon_q <= acc_lon_d;
                            end else begin
                                acc_lat_q <= acc_lat_d;
                            end
                            if (cnt_q == CNT_W'(NDIG - 1)) begin
                                cnt_q   <= '0;
                                state_q <= (state_q == S_LON) ? S_SEP : S_END;
                            end else begin
                                cnt_q <= cnt_q + CNT_W'(1);
                            end
                        end else begin
                            frame_err_q <= 1'b1;
                            state_q     <= S_IDLE;
                        end
                    end
                end
                S_SEP, S_END: begin
                    if (jw_we) begin
                        if (is_dollar_s) begin
                            acc_lon_q <= '0;
                            acc_lat_q <= '0;
                            cnt_q     <= '0;
                            state_q   <= S_LON;
                        end else if (state_q == S_SEP && is_comma_s) begin
                            state_q <= S_LAT;
                        end else if (state_q == S_END && is_star_s) begin
                            state_q <= S_CHECK;
                        end else begin
                            frame_err_q <= 1'b1;
                            state_q     <= S_IDLE;
                        end
                    end
                end
                S_CHECK: begin
                    region_hit_q <= region_s;
                    rem_lon_q    <= '0;
                    rem_lat_q    <= '0;
                    step_q       <= '0;
                    if (region_s) begin
                        dvd_lon_q <= acc_lon_q - COORD_W'(LON_MIN);
                        dvd_lat_q <= acc_lat_q - COORD_W'(LAT_MIN);
                        state_q   <= S_DIV;
                    end else begin
                        state_q <= S_OUT;
                    end
                end
                S_DIV: begin
                    {rem_lon_q, dvd_lon_q} <= div_step(rem_lon_q, dvd_lon_q);
                    {rem_lat_q, dvd_lat_q} <= div_step(rem_lat_q, dvd_lat_q);
                    step_q <= step_q + STEP_W'(1);
                    if (step_q == STEP_W'(COORD_W - 1)) begin
                        state_q <= S_OUT;
                    end
                end
                S_OUT: begin
                    // Outside the region the indices keep their last in-region values.
                    out_valid_q <= 1'b1;
                    in_region_q <= region_hit_q;
                    if (region_hit_q) begin
                        n_q <= sat_idx(dvd_lon_q);
                        m_q <= sat_idx(dvd_lat_q);
                    end
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign m         = m_q;
    assign n         = n_q;
    assign in_region = in_region_q;
    assign out_valid = out_valid_q;
    assign frame_err = frame_err_q;
    assign busy      = (state_q == S_CHECK) || (state_q == S_DIV) || (state_q == S_OUT);

`ifdef GPS_GRID_STAT_EN
    logic [15:0] good_cnt_q, err_cnt_q;

    // Wrapping counters of completed and malformed frames
    always_ff @(posedge clk) begin
        if (!rst) begin
            good_cnt_q <= 16'd0;
            err_cnt_q  <= 16'd0;
        end else begin
            if (out_valid_q) begin
                good_cnt_q <= good_cnt_q + 16'd1;
            end
            if (frame_err_q) begin
                err_cnt_q <= err_cnt_q + 16'd1;
            end
        end
    end

    assign good_cnt = good_cnt_q;
    assign err_cnt  = err_cnt_q;
`endif

endmodule

// File: tb/tb_gps_grid_mapper.sv
// Directed bench for gps_grid_mapper: default instance plus a GRID_W=4 instance sharing the stimulus.
module tb_gps_grid_mapper;

    logic       clk = 1'b0;
    logic       rst;
    logic       jw_we;
    logic [6:0] jw_data;
    logic [8:0] m, n;
    logic [3:0] m4, n4;
    logic       in_region, out_valid, frame_err, busy;
    logic       in_region4, out_valid4, frame_err4, busy4;

    int pass_cnt = 0;
    int tot_cnt  = 0;
    int nv = 0;
    int ne = 0;

    gps_grid_mapper dut (
        .clk(clk), .rst(rst), .jw_we(jw_we), .jw_data(jw_data),
        .m(m), .n(n), .in_region(in_region), .out_valid(out_valid),
        .frame_err(frame_err), .busy(busy)
    );

    gps_grid_mapper #(.GRID_W(4)) dut4 (
        .clk(clk), .rst(rst), .jw_we(jw_we), .jw_data(jw_data),
        .m(m4), .n(n4), .in_region(in_region4), .out_valid(out_valid4),
        .frame_err(frame_err4), .busy(busy4)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (out_valid) nv++;
        if (frame_err) ne++;
    end

    typedef struct {
        string frame;
        bit    is_err;
        int    lat;
        int    exp_m, exp_n, exp_in, exp_m4, exp_n4;
    } vec_t;

    vec_t vq[$];

    task automatic add_vec(input string f, input bit e, input int lat,
                           input int em, input int en, input int ei,
                           input int em4, input int en4);
        vec_t v;
        v.frame = f; v.is_err = e; v.lat = lat;
        v.exp_m = em; v.exp_n = en; v.exp_in = ei; v.exp_m4 = em4; v.exp_n4 = en4;
        vq.push_back(v);
    endtask

    task automatic chk(input string name, input int act, input int exp);
        tot_cnt++;
        if (act != exp) begin
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end else begin
            pass_cnt++;
        end
    endtask

    // Drives one character per cycle; returns #1 after the edge that consumed the last one.
    task automatic send(input string s);
        byte c;
        for (int i = 0; i < s.len(); i++) begin
            @(negedge clk);
            c = s[i];
            jw_we   = 1'b1;
            jw_data = c[6:0];
        end
        @(posedge clk);
        #1;
        jw_we = 1'b0;
    endtask

    initial begin
        int k, seen, v0, e0;
        rst = 1'b0; jw_we = 1'b0; jw_data = 7'h00;

        add_vec("$12345,30050*",     1'b0, 19, 100,  23, 1, 15, 15);
        add_vec("$05000,30050*",     1'b0,  2, 100,  23, 0, 15, 15);
        add_vec("$12A45,30050*",     1'b1,  0, 100,  23, 0, 15, 15);
        add_vec("$11000,21000*",     1'b0, 19,  10,  10, 1, 10, 10);
        add_vec("$123$12345,30050*", 1'b0, 19, 100,  23, 1, 15, 15);
        add_vec("$12345,20000*",     1'b0, 19,   0,  23, 1,  0, 15);
        add_vec("$10000,70000*",     1'b0, 19, 500,   0, 1, 15,  0);
        add_vec("$60000,20000*",     1'b0, 19,   0, 500, 1,  0, 15);
        add_vec("$60001,20000*",     1'b0,  2,   0, 500, 0,  0, 15);
        add_vec("$59999,69999*",     1'b0, 19, 499, 499, 1, 15, 15);
        add_vec("$12345;30050*",     1'b1,  0, 499, 499, 1, 15, 15);
        add_vec("$09999,30000*",     1'b0,  2, 499, 499, 0, 15, 15);
        add_vec("$30000,70001*",     1'b0,  2, 499, 499, 0, 15, 15);

        repeat (3) @(posedge clk);
        #1;
        chk("rst_m", m, 0); chk("rst_n", n, 0); chk("rst_in", in_region, 0);
        chk("rst_valid", out_valid, 0); chk("rst_err", frame_err, 0); chk("rst_busy", busy, 0);
        rst = 1'b1;
        repeat (2) @(posedge clk);

        foreach (vq[i]) begin
            v0 = nv; e0 = ne;
            send(vq[i].frame);
            k = 0; seen = 0;
            for (int c = 1; c <= 30; c++) begin
                @(posedge clk);
                #1;
                if (seen == 0 && out_valid) begin
                    seen = 1;
                    k = c;
                end
            end
            if (vq[i].is_err) begin
                chk($sformatf("v%0d_novalid", i), seen, 0);
            end else begin
                chk($sformatf("v%0d_latency", i), k, vq[i].lat);
            end
            chk($sformatf("v%0d_valid_cnt", i), nv - v0, vq[i].is_err ? 0 : 1);
            chk($sformatf("v%0d_err_cnt", i), ne - e0, vq[i].is_err ? 1 : 0);
            chk($sformatf("v%0d_m", i), m, vq[i].exp_m);
            chk($sformatf("v%0d_n", i), n, vq[i].exp_n);
            chk($sformatf("v%0d_in", i), in_region, vq[i].exp_in);
            chk($sformatf("v%0d_m4", i), m4, vq[i].exp_m4);
            chk($sformatf("v%0d_n4", i), n4, vq[i].exp_n4);
        end

        // frame_err lands in the cycle after the offending character
        send("$12A");
        chk("err_pulse", frame_err, 1);
        @(posedge clk);
        #1;
        chk("err_pulse_end", frame_err, 0);
        chk("err_hold_m", m, 499);

        // back-to-back frame whose '$' arrives while busy
        v0 = nv;
        send("$12345,30050*");
        chk("busy_check", busy, 1);
        send("$11000,21000*");
        repeat (40) @(posedge clk);
        #1;
        chk("b2b_valid_cnt", nv - v0, 1);
        chk("b2b_m", m, 100);
        chk("b2b_n", n, 23);
        chk("b2b_busy_idle", busy, 0);

        // reset during the divide aborts silently
        v0 = nv; e0 = ne;
        send("$11000,21000*");
        repeat (5) @(posedge clk);
        #1;
        chk("div_busy", busy, 1);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        chk("mid_rst_m", m, 0); chk("mid_rst_n", n, 0); chk("mid_rst_in", in_region, 0);
        chk("mid_rst_busy", busy, 0); chk("mid_rst_m4", m4, 0); chk("mid_rst_n4", n4, 0);
        repeat (30) @(posedge clk);
        #1;
        chk("mid_rst_no_valid", nv - v0, 0);
        chk("mid_rst_no_err", ne - e0, 0);

        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

endmodule

// File: doc/gps_grid_mapper.md
Name: gps_grid_mapper

Overview:
- Parametrised successor to the fixed-width longitude/latitude processing path.
- Parses a serial ASCII GPS coordinate frame into binary longitude and latitude, checks both against a configurable rectangular region, and maps them to grid cell indices with a sequential divider.
- Sits between the GPS character source (write strobe plus 7-bit character) and the map/display logic that consumes grid indices m, n and the in_region flag.

Parameters:
NDIG, 5, decimal digits per coordinate field
COORD_W, 17, binary coordinate width; must satisfy 2^COORD_W > 10^NDIG-1
GRID_W, 9, grid index width
LON_MIN, 10000, lowest in-region longitude (coordinate units)
LON_MAX, 60000, highest in-region longitude
LAT_MIN, 20000, lowest in-region latitude
LAT_MAX, 70000, highest in-region latitude
CELL, 100, grid cell size in coordinate units (>=1)

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-low
jw_we  in  1  character strobe, one char per high cycle
jw_data  in  7  ASCII character
m  out  GRID_W  latitude grid index
n  out  GRID_W  longitude grid index
in_region  out  1  last completed frame lies inside the region
out_valid  out  1  one-cycle pulse when m/n/in_region update
frame_err  out  1  one-cycle pulse on malformed frame
busy  out  1  high in CHECK/DIV/OUT; characters are ignored

Behaviour:
- Reset (rst=0 at a clk edge): m=0, n=0, in_region=0, out_valid=0, frame_err=0, busy=0, FSM to IDLE, accumulators cleared.
- Frame format: '$', NDIG lon digits, ',', NDIG lat digits, '*'. Only cycles with jw_we=1 consume characters.
- FSM states:
  - IDLE: wait for '$'; all other characters are dropped silently.
  - LON: each digit updates acc_lon <= acc_lon*10 + (char-'0'). After NDIG digits go to SEP.
  - SEP: ',' goes to LAT.
  - LAT: same accumulation into acc_lat. After NDIG digits go to END.
  - END: '*' goes to CHECK.
  - CHECK (1 cycle): in-region test is LON_MIN<=lon<=LON_MAX and LAT_MIN<=lat<=LAT_MAX. Inside: load dividends lon-LON_MIN and lat-LAT_MIN, go to DIV. Outside: go to OUT.
  - DIV (exactly COORD_W cycles): two parallel restoring dividers by CELL, one bit per cycle, MSB first. Then OUT.
  - OUT (1 cycle): register outputs, pulse out_valid, return to IDLE.
- Output update rules:
  - Inside: n = lon-quotient, m = lat-quotient. A quotient > 2^GRID_W-1 saturates to 2^GRID_W-1. in_region=1.
  - Outside: m and n hold their previous values; in_region=0.
- Latency, with '*' sampled at edge N:
  - Inside: out_valid high during cycle N+COORD_W+2.
  - Outside: out_valid high during cycle N+2.
- Errors:
  - A wrong character in LON, SEP, LAT or END (non-digit where a digit is expected, missing ',' or '*') pulses frame_err the next cycle and returns to IDLE.
  - Outputs are unchanged by an error.
- '$' received in LON, SEP, LAT or END restarts the frame: accumulators cleared, go to LON, no frame_err.
- Characters arriving while busy=1 are dropped, including '$'.
- Reset mid-frame or mid-divide aborts with no out_valid and no frame_err.
- m, n and in_region change only in the OUT cycle; they are stable otherwise.

Optional Feature:
- Macro: GPS_GRID_STAT_EN.
- Defined:
  - Adds outputs good_cnt[15:0] (increments on each out_valid) and err_cnt[15:0] (increments on each frame_err).
  - Both counters wrap 0xFFFF to 0 and reset to 0.
- Undefined: the ports and counters do not exist; all other behaviour is identical.

Test Plan:
- "$12345,30050*" with defaults -> out_valid at N+19, n=23, m=100, in_region=1, frame_err never high.
- After the first frame, "$05000,30050*" -> out_valid at N+2, in_region=0, m=100 and n=23 held.
- "$12A45,30050*" -> frame_err pulse the cycle after 'A', no out_valid, outputs unchanged; a following valid frame is parsed correctly.
- "$123$12345,30050*" -> restart at the second '$', result n=23, m=100, no frame_err.
- Frame sent back-to-back so its '$' arrives while busy=1 -> that frame is ignored, only the first out_valid occurs.
- GRID_W=4, CELL=100, "$12345,20000*" -> n saturates to 15, m=0, in_region=1. Separately, rst low during DIV -> all outputs 0, no out_valid.
